branch_resolver: RTL
====================

Name: branch_resolver

Overview:
- EX-stage counterpart to the fetch-side hazard/prediction logic.
- Receives each branch/jump with the prediction fetch made for it, resolves the real outcome and target, and compares them.
- On mismatch, issues a redirect PC and a multi-cycle flush to IF/ID.
- Owns the 2-bit saturating branch history table (BHT): fetch reads it; this block trains it.

Parameters:
- BHT_BITS, 6, log2 of BHT entries (64); index = pc[BHT_BITS+1:2]
- FLUSH_CYCLES, 2, cycles flush stays asserted after a mispredict
- CNT_W, 32, width of the saturating statistics counters

Ports:
- clk  in  1  clock; all state updates on posedge
- rstn  in  1  synchronous reset, active-high (port keeps codebase name)
- if_pc  in  32  fetch PC for prediction lookup
- if_pred_taken  out  1  combinational: BHT[idx(if_pc)][1]
- ex_valid  in  1  EX slot holds a real instruction
- ex_inst  in  32  EX instruction (opcode [6:0], funct3 [14:12])
- ex_pc  in  32  PC of EX instruction
- ex_imm  in  32  sign-extended B/J immediate
- ex_rs1  in  32  forwarded rs1 value
- ex_rs2  in  32  forwarded rs2 value
- ex_pred_taken  in  1  prediction made at fetch
- ex_pred_target  in  32  target fetch used if predicted taken
- flush  out  1  kill IF/ID contents
- redirect  out  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  out  32  corrected fetch address
- branch_cnt  out  CNT_W  resolved branches/jumps
- mispred_cnt  out  CNT_W  mispredictions

Behaviour:
- Reset (rstn=1 at posedge):
  - All BHT entries set to 2'b01 (weak not-taken).
  - flush, redirect, redirect_pc, both counters, and the flush-hold counter set to 0.
  - Reset mid-flush aborts the flush.
- Instruction classes:
  - Branch: opcode 1100011.
    - funct3 000 beq (eq), 001 bne (ne), 100 blt (signed lt), 101 bge (signed ge), 110 bltu (unsigned lt), 111 bgeu (unsigned ge).
    - funct3 010/011 are illegal: treated as not-taken, no BHT update, no counter update.
  - JAL: opcode 1101111, always taken.
  - Any other opcode: ignored entirely.
- Resolution (combinational within the EX cycle):
  - actual_target = ex_pc + ex_imm, mod 2^32.
  - Correct next PC: actual_target if taken, else ex_pc + 4.
- Mispredict conditions:
  - pred_taken != actual_taken, or
  - both taken and ex_pred_target != actual_target.
- Accepted instruction: ex_valid=1, recognised branch/JAL, and flush-hold counter == 0. Instructions arriving while flush is active are wrong-path and are dropped.
- Accepted branch/JAL: branch_cnt increments at the next posedge.
- Accepted conditional branch: BHT[idx(ex_pc)] saturating update; taken increments to max 11, not-taken decrements to min 00. JAL does not train the BHT.
- Accepted mispredict, registered at the next posedge:
  - redirect=1 for exactly 1 cycle.
  - redirect_pc = correct next PC, held until the next redirect.
  - flush=1 for FLUSH_CYCLES consecutive cycles, starting the same cycle as redirect.
  - mispred_cnt increments.
- Latency: resolution to redirect/flush is 1 cycle.
- Counters saturate at all-ones; no wrap.
- BHT read/write same index in the same cycle: if_pred_taken returns the pre-update value (read-before-write).
- BHT is a flop array, not a RAM, so the read can stay combinational.

Decomposition:
- Shared package:
  - opcode constants OP_BRANCH, OP_JAL.
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - BHT counter encodings SNT, WNT, WT, ST.
- Sub-module bht_2bit:
  - Counter array, combinational read port, saturating write port, reset-to-WNT.
- Compare/target logic stays in the top level.

Test Plan:
- beq, rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 → next cycle redirect=1, redirect_pc=0x120; flush high 2 cycles; mispred_cnt=1; BHT[0x00] 01→10.
- bne, rs1=rs2, pred_taken=0 → no redirect, no flush; branch_cnt+1; BHT entry 01→00; a second repeat keeps it at 00.
- blt with rs1=0xFFFFFFFF, rs2=1 → taken (signed). bltu with the same values → not taken. Both checked against pred_taken=1, target=pc+imm.
- JAL, pc=0x40, imm=0x80, pred_taken=1, pred_target=0xC4 → redirect_pc=0xC0 (target mismatch); BHT unchanged.
- Mispredict followed immediately by a valid beq in each flush cycle → both beqs dropped; counters and BHT unchanged.
- rstn asserted during the second flush cycle → flush=0 next cycle; all BHT reads return 0; counters 0.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared encodings for the EX-stage branch resolver and its history table.
package branch_resolver_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_t;

    function automatic bht_cnt_t bht_next(input bht_cnt_t cur, input logic taken);
        bht_cnt_t nxt;
        nxt = cur;
        case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolver_bht_2bit.sv
// 2-bit saturating branch history table held in flops so the fetch read stays combinational.
module bht_2bit
    import branch_resolver_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_taken,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    bht_cnt_t r_cnt [ENTRIES];

    // Read sees the pre-update value when read and write hit the same entry.
    assign o_rd_taken = r_cnt[i_rd_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_cnt[i] <= WNT;
            end
        end else if (i_wr_en) begin
            r_cnt[i_wr_idx] <= bht_next(r_cnt[i_wr_idx], i_wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves EX-stage branches/JAL against the fetch prediction, redirects and flushes on mispredict.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int BHT_BITS     = 6,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic [31:0]      ex_inst,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_rs1,
    input  logic [31:0]      ex_rs2,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             flush,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    logic [FC_W-1:0]  r_flush_left;
    logic             r_redirect;
    logic [31:0]      r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic        w_is_branch;
    logic        w_is_jal;
    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;
    logic        w_mispred;
    logic        w_accept;
    logic        w_eq;
    logic        w_lt_s;
    logic        w_lt_u;

    assign w_opcode    = ex_inst[6:0];
    assign w_f3        = ex_inst[14:12];
    // funct3 010/011 are not real branches; they never train or count.
    assign w_is_branch = (w_opcode == OP_BRANCH) && (w_f3 != 3'b010) && (w_f3 != 3'b011);
    assign w_is_jal    = (w_opcode == OP_JAL);

    assign w_eq   = (ex_rs1 == ex_rs2);
    assign w_lt_s = ($signed(ex_rs1) < $signed(ex_rs2));
    assign w_lt_u = (ex_rs1 < ex_rs2);

    always_comb begin
        w_taken = 1'b0;
        if (w_is_jal) begin
            w_taken = 1'b1;
        end else if (w_is_branch) begin
            case (w_f3)
                F3_BEQ:  w_taken = w_eq;
                F3_BNE:  w_taken = !w_eq;
                F3_BLT:  w_taken = w_lt_s;
                F3_BGE:  w_taken = !w_lt_s;
                F3_BLTU: w_taken = w_lt_u;
                F3_BGEU: w_taken = !w_lt_u;
                default: w_taken = 1'b0;
            endcase
        end
    end

    assign w_target  = ex_pc + ex_imm;
    assign w_next_pc = w_taken ? w_target : (ex_pc + 32'd4);
    assign w_mispred = (ex_pred_taken != w_taken) ||
                       (w_taken && (ex_pred_target != w_target));
    // Anything arriving while the flush is held is wrong-path.
    assign w_accept  = ex_valid && (w_is_branch || w_is_jal) && (r_flush_left == '0);

    bht_2bit #(.IDX_W(BHT_BITS)) u_bht (
        .clk        (clk),
        .rst        (rstn),
        .i_rd_idx   (if_pc[BHT_BITS+1:2]),
        .o_rd_taken (if_pred_taken),
        .i_wr_en    (w_accept && w_is_branch),
        .i_wr_idx   (ex_pc[BHT_BITS+1:2]),
        .i_wr_taken (w_taken)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_flush_left  <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_redirect <= 1'b0;
            if (r_flush_left != '0) begin
                r_flush_left <= r_flush_left - FC_W'(1);
            end
            if (w_accept) begin
                if (r_branch_cnt != '1) begin
                    r_branch_cnt <= r_branch_cnt + CNT_W'(1);
                end
                if (w_mispred) begin
                    r_redirect    <= 1'b1;
                    r_redirect_pc <= w_next_pc;
                    r_flush_left  <= FC_W'(FLUSH_CYCLES);
                    if (r_mispred_cnt != '1) begin
                        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign flush       = (r_flush_left != '0);
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
